// File: rtl/pulse_train_gen.sv
// pulse_train_gen
//   Programmable pulse-train generator. An accepted start latches a pulse
//   count N, a high time H and a low time L (a zero time is treated as one
//   cycle). The block then emits N registered pulses on wave_out, each H
//   cycles high followed by L cycles low. It counts the rising and falling
//   edges it actually produces.
//
// Ports
//   clk         system clock, rising edge
//   reset       asynchronous active-low reset
//   start       one-cycle request, honoured only while idle
//   abort       synchronous stop, honoured only while a train is running
//   num_pulses  pulse count N, latched on an accepted start
//   high_cycles high time per pulse in clk cycles, latched on start
//   low_cycles  low time per pulse in clk cycles, latched on start
//   wave_out    generated waveform
//   busy        train in progress
//   done        one-cycle strobe on normal completion
//   pos_cnt     rising edges emitted in the current or last train
//   neg_cnt     falling edges emitted in the current or last train
module pulse_train_gen #(
    parameter int CNT_W = 8,
    parameter int TW    = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic [CNT_W-1:0] num_pulses,
    input  logic [TW-1:0]    high_cycles,
    input  logic [TW-1:0]    low_cycles,
    output logic             wave_out,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] pos_cnt,
    output logic [CNT_W-1:0] neg_cnt
);

    typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

    localparam logic [TW:0]    PH_ONE  = (TW+1)'(1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] n_lat, n_nxt;
    // Phase times and the phase counter carry one spare bit so that the
    // largest programmable time cannot wrap the counter.
    logic [TW:0]      h_lat, h_nxt;
    logic [TW:0]      l_lat, l_nxt;
    logic [TW:0]      ph_cnt, ph_nxt;
    logic             wave_nxt, busy_nxt, done_nxt;
    logic [CNT_W-1:0] pos_nxt, neg_nxt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            n_lat    <= '0;
            h_lat    <= '0;
            l_lat    <= '0;
            ph_cnt   <= '0;
            wave_out <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            pos_cnt  <= '0;
            neg_cnt  <= '0;
        end else begin
            state    <= state_nxt;
            n_lat    <= n_nxt;
            h_lat    <= h_nxt;
            l_lat    <= l_nxt;
            ph_cnt   <= ph_nxt;
            wave_out <= wave_nxt;
            busy     <= busy_nxt;
            done     <= done_nxt;
            pos_cnt  <= pos_nxt;
            neg_cnt  <= neg_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        n_nxt     = n_lat;
        h_nxt     = h_lat;
        l_nxt     = l_lat;
        ph_nxt    = ph_cnt;
        wave_nxt  = wave_out;
        busy_nxt  = busy;
        done_nxt  = 1'b0;
        pos_nxt   = pos_cnt;
        neg_nxt   = neg_cnt;

        case (state)
            IDLE: begin
                if (start) begin
                    n_nxt   = num_pulses;
                    h_nxt   = (high_cycles == '0) ? PH_ONE : {1'b0, high_cycles};
                    l_nxt   = (low_cycles == '0)  ? PH_ONE : {1'b0, low_cycles};
                    pos_nxt = '0;
                    neg_nxt = '0;
                    ph_nxt  = '0;
                    if (num_pulses == '0) begin
                        // Empty train: report completion without ever going busy.
                        done_nxt = 1'b1;
                    end else begin
                        state_nxt = HIGH;
                        wave_nxt  = 1'b1;
                        busy_nxt  = 1'b1;
                        pos_nxt   = CNT_ONE;
                        ph_nxt    = PH_ONE;
                    end
                end
            end

            HIGH: begin
                // ph_cnt holds the number of cycles already spent in the phase,
                // including the current one.
                if (abort) begin
                    state_nxt = IDLE;
                    wave_nxt  = 1'b0;
                    busy_nxt  = 1'b0;
                    ph_nxt    = '0;
                    if (wave_out) neg_nxt = neg_cnt + CNT_ONE;
                end else if (ph_cnt >= h_lat) begin
                    state_nxt = LOW;
                    wave_nxt  = 1'b0;
                    neg_nxt   = neg_cnt + CNT_ONE;
                    ph_nxt    = PH_ONE;
                end else begin
                    ph_nxt = ph_cnt + PH_ONE;
                end
            end

            LOW: begin
                if (abort) begin
                    state_nxt = IDLE;
                    wave_nxt  = 1'b0;
                    busy_nxt  = 1'b0;
                    ph_nxt    = '0;
                    if (wave_out) neg_nxt = neg_cnt + CNT_ONE;
                end else if (ph_cnt >= l_lat) begin
                    // pos_cnt doubles as the count of pulses already emitted.
                    if (pos_cnt < n_lat) begin
                        state_nxt = HIGH;
                        wave_nxt  = 1'b1;
                        pos_nxt   = pos_cnt + CNT_ONE;
                        ph_nxt    = PH_ONE;
                    end else begin
                        state_nxt = IDLE;
                        busy_nxt  = 1'b0;
                        done_nxt  = 1'b1;
                        ph_nxt    = '0;
                    end
                end else begin
                    ph_nxt = ph_cnt + PH_ONE;
                end
            end

            default: begin
                state_nxt = IDLE;
                wave_nxt  = 1'b0;
                busy_nxt  = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_pulse_train_gen.sv
module tb_pulse_train_gen;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [7:0] num_pulses = '0;
    logic [7:0] high_cycles = '0;
    logic [7:0] low_cycles = '0;
    logic       wave_out, busy, done;
    logic [7:0] pos_cnt, neg_cnt;

    pulse_train_gen #(.CNT_W(8), .TW(8)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .abort       (abort),
        .num_pulses  (num_pulses),
        .high_cycles (high_cycles),
        .low_cycles  (low_cycles),
        .wave_out    (wave_out),
        .busy        (busy),
        .done        (done),
        .pos_cnt     (pos_cnt),
        .neg_cnt     (neg_cnt)
    );

    always #5 clk = ~clk;

    // Cycle number; cycle c is the interval after the c-th rising edge.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Expected outputs tagged with the cycle they belong to. cnt=0 checks
    // wave/busy/done, cnt=1 checks the edge counters.
    typedef struct {
        int         cyc;
        bit         cnt;
        logic       w, b, d;
        logic [7:0] p, n;
        string      tag;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   vectors = 0;
    int   miscompares = 0;

    function automatic void push(exp_t x);
        int i = 0;
        while (i < sb.size() && sb[i].cyc <= x.cyc) i++;
        sb.insert(i, x);
    endfunction

    // Strings give the expected level for cycles t0+1, t0+2, ...
    task automatic expect_trace(string tag, int t0, string w, string b, string d);
        for (int i = 0; i < w.len(); i++) begin
            exp_t x;
            x.cyc = t0 + 1 + i;
            x.cnt = 1'b0;
            x.w   = (w[i] == "1");
            x.b   = (b[i] == "1");
            x.d   = (d[i] == "1");
            x.p   = '0;
            x.n   = '0;
            x.tag = tag;
            push(x);
        end
    endtask

    task automatic expect_cnt(string tag, int c, int p, int n);
        exp_t x;
        x.cyc = c;
        x.cnt = 1'b1;
        x.w   = 1'b0;
        x.b   = 1'b0;
        x.d   = 1'b0;
        x.p   = 8'(p);
        x.n   = 8'(n);
        x.tag = tag;
        push(x);
    endtask

    // Monitor: compares on the falling edge, away from the active edge.
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            vectors++;
            if (e.cyc != cyc) begin
                miscompares++;
                $display("FAIL %s: vector for cycle %0d missed (now cycle %0d)", e.tag, e.cyc, cyc);
            end else if (e.cnt) begin
                if (pos_cnt !== e.p || neg_cnt !== e.n) begin
                    miscompares++;
                    $display("FAIL %s cyc=%0d: got pos=%0d neg=%0d, want pos=%0d neg=%0d",
                             e.tag, cyc, pos_cnt, neg_cnt, e.p, e.n);
                end
            end else if ({wave_out, busy, done} !== {e.w, e.b, e.d}) begin
                miscompares++;
                $display("FAIL %s cyc=%0d: got wave=%b busy=%b done=%b, want wave=%b busy=%b done=%b",
                         e.tag, cyc, wave_out, busy, done, e.w, e.b, e.d);
            end
        end
    end

    task automatic goto(int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_start(int n, int h, int l);
        num_pulses  = 8'(n);
        high_cycles = 8'(h);
        low_cycles  = 8'(l);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic do_abort();
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;

        // Reset state.
        expect_trace("reset", 0, "00", "00", "00");
        expect_cnt("reset_cnt", 1, 0, 0);
        goto(3);
        reset = 1'b1;

        // Reset mid-train kills it at once, no done afterwards.
        goto(5);
        t = cyc;
        expect_trace("rst_mid", t, "100000", "100000", "000000");
        expect_cnt("rst_mid_cnt1", t + 1, 1, 0);
        expect_cnt("rst_mid_cnt2", t + 2, 0, 0);
        expect_cnt("rst_mid_cnt3", t + 6, 0, 0);
        do_start(5, 3, 2);
        goto(t + 2);
        reset = 1'b0;
        goto(t + 4);
        reset = 1'b1;

        // N=3 H=2 L=1.
        goto(t + 8);
        t = cyc;
        expect_trace("basic", t, "11011011000", "11111111100", "00000000010");
        expect_cnt("basic_cnt1", t + 1, 1, 0);
        expect_cnt("basic_cnt3", t + 3, 1, 1);
        expect_cnt("basic_cnt10", t + 10, 3, 3);
        do_start(3, 2, 1);

        // N=0: done next cycle, never busy, counts cleared.
        goto(t + 12);
        t = cyc;
        expect_trace("n0", t, "000", "000", "100");
        expect_cnt("n0_cnt1", t + 1, 0, 0);
        expect_cnt("n0_cnt3", t + 3, 0, 0);
        do_start(0, 4, 4);

        // Zero high/low times behave as one cycle.
        goto(t + 4);
        t = cyc;
        expect_trace("hl0", t, "1010101000", "1111111100", "0000000010");
        expect_cnt("hl0_cnt4", t + 4, 2, 2);
        expect_cnt("hl0_cnt9", t + 9, 4, 4);
        do_start(4, 0, 0);

        // Abort during the high phase of the second pulse.
        goto(t + 11);
        t = cyc;
        expect_trace("abort_hi", t, "1111000011000", "1111111111000", "0000000000000");
        expect_cnt("abort_hi_cnt10", t + 10, 2, 1);
        expect_cnt("abort_hi_cnt11", t + 11, 2, 2);
        expect_cnt("abort_hi_cnt13", t + 13, 2, 2);
        do_start(10, 4, 4);
        goto(t + 10);
        do_abort();

        // Abort in a low phase, then abort while idle is ignored.
        goto(t + 14);
        t = cyc;
        expect_trace("abort_lo", t, "11000000", "11110000", "00000000");
        expect_cnt("abort_lo_cnt5", t + 5, 1, 1);
        expect_cnt("abort_idle_cnt8", t + 8, 1, 1);
        do_start(3, 2, 3);
        goto(t + 4);
        do_abort();
        goto(t + 6);
        do_abort();

        // Start while busy is ignored; start in the done cycle is taken.
        goto(t + 10);
        t = cyc;
        expect_trace("restart", t, "110011000100", "111111110110", "000000001001");
        expect_cnt("restart_cnt9", t + 9, 2, 2);
        expect_cnt("restart_cnt10", t + 10, 1, 0);
        expect_cnt("restart_cnt12", t + 12, 1, 1);
        do_start(2, 2, 2);
        goto(t + 3);
        do_start(7, 5, 5);
        goto(t + 9);
        do_start(1, 1, 1);

        goto(t + 16);
        if (sb.size() != 0) begin
            miscompares += sb.size();
            $display("FAIL drain: %0d expected vectors never checked, want 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
